// File: rtl/glb_arbiter.sv
// +------------------------------------------------------------------------+
// | glb_arbiter: two-requester round-robin arbiter for the GLB port set,   |
// | with burst lock, starvation cap and 1-cycle read-return routing.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module glb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    t_req,
  input  logic                    p_req,
  input  logic                    t_lock,
  input  logic                    p_lock,
  output logic                    t_gnt,
  output logic                    p_gnt,
  input  logic [3:0]              t_re,
  input  logic [3:0]              p_re,
  input  logic [3:0]              t_we,
  input  logic [3:0]              p_we,
  input  logic [ADDR_WIDTH-1:0]   t_addr,
  input  logic [ADDR_WIDTH-1:0]   p_addr,
  input  logic [DATA_WIDTH*4-1:0] t_wdata,
  input  logic [DATA_WIDTH*4-1:0] p_wdata,
  output logic [DATA_WIDTH*4-1:0] t_rdata,
  output logic [DATA_WIDTH*4-1:0] p_rdata,
  output logic                    t_rvalid,
  output logic                    p_rvalid,
  output logic [3:0]              glb_re,
  output logic [3:0]              glb_we,
  output logic [ADDR_WIDTH-1:0]   glb_r_addr,
  output logic [ADDR_WIDTH-1:0]   glb_w_addr,
  output logic [DATA_WIDTH*4-1:0] glb_w_data,
  input  logic [DATA_WIDTH*4-1:0] glb_r_data
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] c_MAX_BURST = BW'(MAX_BURST);
  localparam logic [BW-1:0] c_ONE       = BW'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_T    = 2'd1,
    OWN_P    = 2'd2
  } owner_e;

  owner_e          r_owner;
  owner_e          r_rd_own;
  logic            r_rr_p;
  logic [BW-1:0]   r_burst;
  logic            r_rd_pend;

  owner_e          w_winner;
  owner_e          w_owner_nxt;
  logic            w_own_req;
  logic            w_oth_req;
  logic [BW-1:0]   w_burst_nxt;

  // Winner selection: a locked owner keeps the port unless the cap is hit under contention
  always_comb begin
    w_own_req = 1'b0;
    w_oth_req = 1'b0;
    w_winner  = OWN_NONE;
    case (r_owner)
      OWN_T: begin
        w_own_req = t_req;
        w_oth_req = p_req;
      end
      OWN_P: begin
        w_own_req = p_req;
        w_oth_req = t_req;
      end
      default: ;
    endcase
    if (rst) begin
      w_winner = OWN_NONE;
    end else if (r_owner != OWN_NONE && w_own_req &&
                 (r_burst < c_MAX_BURST || !w_oth_req)) begin
      w_winner = r_owner;
    end else if (t_req && !p_req) begin
      w_winner = OWN_T;
    end else if (p_req && !t_req) begin
      w_winner = OWN_P;
    end else if (t_req && p_req) begin
      w_winner = r_rr_p ? OWN_P : OWN_T;
    end
  end

  always_comb begin
    t_gnt      = 1'b0;
    p_gnt      = 1'b0;
    glb_re     = '0;
    glb_we     = '0;
    glb_r_addr = '0;
    glb_w_addr = '0;
    glb_w_data = '0;
    case (w_winner)
      OWN_T: begin
        t_gnt      = 1'b1;
        glb_re     = t_re;
        glb_we     = t_we;
        glb_r_addr = t_addr;
        glb_w_addr = t_addr;
        glb_w_data = t_wdata;
      end
      OWN_P: begin
        p_gnt      = 1'b1;
        glb_re     = p_re;
        glb_we     = p_we;
        glb_r_addr = p_addr;
        glb_w_addr = p_addr;
        glb_w_data = p_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_winner == OWN_T && t_lock) begin
      w_owner_nxt = OWN_T;
    end else if (w_winner == OWN_P && p_lock) begin
      w_owner_nxt = OWN_P;
    end
    w_burst_nxt = c_ONE;
    if (w_winner == r_owner) begin
      w_burst_nxt = (r_burst == c_MAX_BURST) ? r_burst : r_burst + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= OWN_NONE;
      r_rr_p    <= 1'b0;
      r_burst   <= c_ONE;
      r_rd_pend <= 1'b0;
      r_rd_own  <= OWN_NONE;
    end else begin
      r_owner   <= w_owner_nxt;
      r_burst   <= w_burst_nxt;
      r_rd_pend <= |glb_re;
      r_rd_own  <= w_winner;
      if (w_winner != OWN_NONE) begin
        r_rr_p <= (w_winner == OWN_T);
      end
    end
  end

  assign t_rvalid = !rst && r_rd_pend && (r_rd_own == OWN_T);
  assign p_rvalid = !rst && r_rd_pend && (r_rd_own == OWN_P);
  assign t_rdata  = glb_r_data;
  assign p_rdata  = glb_r_data;

endmodule

`default_nettype wire

// File: tb/tb_glb_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_glb_arbiter: randomized and directed bench for glb_arbiter against  |
// | a side-indexed behavioural model.  Revision: 1.0                       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_glb_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          t_req, p_req, t_lock, p_lock;
  logic          t_gnt, p_gnt;
  logic [3:0]    t_re, p_re, t_we, p_we;
  logic [AW-1:0] t_addr, p_addr;
  logic [31:0]   t_wdata, p_wdata;
  logic [31:0]   t_rdata, p_rdata;
  logic          t_rvalid, p_rvalid;
  logic [3:0]    glb_re, glb_we;
  logic [AW-1:0] glb_r_addr, glb_w_addr;
  logic [31:0]   glb_w_data, glb_r_data;

  always #5 clk = ~clk;

  glb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .t_req(t_req), .p_req(p_req), .t_lock(t_lock), .p_lock(p_lock),
    .t_gnt(t_gnt), .p_gnt(p_gnt),
    .t_re(t_re), .p_re(p_re), .t_we(t_we), .p_we(p_we),
    .t_addr(t_addr), .p_addr(p_addr), .t_wdata(t_wdata), .p_wdata(p_wdata),
    .t_rdata(t_rdata), .p_rdata(p_rdata), .t_rvalid(t_rvalid), .p_rvalid(p_rvalid),
    .glb_re(glb_re), .glb_we(glb_we), .glb_r_addr(glb_r_addr), .glb_w_addr(glb_w_addr),
    .glb_w_data(glb_w_data), .glb_r_data(glb_r_data)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: sides are 1 (T) and 2 (P), 0 means nobody
  int m_owner, m_rr, m_burst, m_pend, m_rown;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs applied; checks, clocks, advances the model.
  task automatic step(output logic [1:0] gnt_obs);
    int rq[3];
    int lk[3];
    int w;
    logic [3:0]  e_re [3];
    logic [3:0]  e_we [3];
    logic [31:0] e_ad [3];
    logic [31:0] e_wd [3];
    rq[0] = 0; rq[1] = int'(t_req); rq[2] = int'(p_req);
    lk[0] = 0; lk[1] = int'(t_lock); lk[2] = int'(p_lock);
    e_re[0] = 4'h0; e_re[1] = t_re;    e_re[2] = p_re;
    e_we[0] = 4'h0; e_we[1] = t_we;    e_we[2] = p_we;
    e_ad[0] = '0;   e_ad[1] = t_addr;  e_ad[2] = p_addr;
    e_wd[0] = '0;   e_wd[1] = t_wdata; e_wd[2] = p_wdata;
    #1;
    if (rst) w = 0;
    else if (m_owner != 0 && rq[m_owner] == 1 && (m_burst < MB || rq[3 - m_owner] == 0)) w = m_owner;
    else if (rq[1] + rq[2] == 1) w = (rq[1] == 1) ? 1 : 2;
    else if (rq[1] + rq[2] == 2) w = m_rr;
    else w = 0;

    check_eq("t_gnt", t_gnt, (w == 1));
    check_eq("p_gnt", p_gnt, (w == 2));
    check_eq("glb_re", glb_re, e_re[w]);
    check_eq("glb_we", glb_we, e_we[w]);
    check_eq("glb_r_addr", glb_r_addr, e_ad[w]);
    check_eq("glb_w_addr", glb_w_addr, e_ad[w]);
    check_eq("glb_w_data", glb_w_data, e_wd[w]);
    check_eq("t_rvalid", t_rvalid, (!rst && m_pend == 1 && m_rown == 1));
    check_eq("p_rvalid", p_rvalid, (!rst && m_pend == 1 && m_rown == 2));
    check_eq("t_rdata", t_rdata, glb_r_data);
    check_eq("p_rdata", p_rdata, glb_r_data);
    gnt_obs = {p_gnt, t_gnt};

    @(posedge clk);
    if (rst) begin
      m_owner = 0; m_rr = 1; m_burst = 1; m_pend = 0; m_rown = 0;
    end else begin
      m_burst = (w == m_owner) ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 1;
      m_owner = (w != 0 && lk[w] == 1) ? w : 0;
      if (w != 0) m_rr = 3 - w;
      m_pend  = (e_re[w] != 4'h0) ? 1 : 0;
      m_rown  = w;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    t_req = 0; p_req = 0; t_lock = 0; p_lock = 0;
    t_re = 0; p_re = 0; t_we = 0; p_we = 0;
    t_addr = 0; p_addr = 0; t_wdata = 0; p_wdata = 0;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] gs [20];
    int run;
    int cnt;
    rst = 1'b1;
    glb_r_data = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_owner = 0; m_rr = 1; m_burst = 1; m_pend = 0; m_rown = 0;

    // Reset holds off grants even with both sides requesting
    t_req = 1; p_req = 1; t_re = 4'hF; p_we = 4'h3;
    step(g);
    check_eq("rst_gnt", g, 2'b00);

    // Plain contention after reset: T first, then alternate
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_addr = $urandom; p_addr = $urandom; t_re = 4'hF; p_re = 4'h3; p_we = 4'h1;
      t_wdata = $urandom; p_wdata = $urandom; glb_r_data = $urandom;
      step(g);
      check_eq("rr_seq", g, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Read routing to P
    idle_inputs();
    p_req = 1; p_re = 4'hF; p_addr = 32'h100;
    step(g);
    idle_inputs();
    glb_r_data = 32'h44332211;
    #1;
    check_eq("rd_p_rvalid", p_rvalid, 1'b1);
    check_eq("rd_t_rvalid", t_rvalid, 1'b0);
    check_eq("rd_p_rdata", p_rdata, 32'h44332211);
    step(g);

    // Burst lock with a starvation cap
    for (int i = 0; i < 20; i++) begin
      t_req = 1; t_lock = 1; p_req = (i >= 2);
      t_addr = $urandom; p_addr = $urandom;
      step(g);
      gs[i] = g;
    end
    run = 0;
    while (run < 20 && gs[run] == 2'b01) run++;
    check_eq("burst_len", run, MB);
    check_eq("burst_break", gs[16], 2'b10);
    idle_inputs();
    step(g);

    // Lock with no contention is never capped
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      t_req = 1; t_lock = 1;
      step(g);
      if (g == 2'b01) cnt++;
    end
    check_eq("lock_alone", cnt, 30);

    // Reset in the middle of a reading burst
    for (int i = 0; i < 3; i++) begin
      t_re = 4'hF; t_addr = $urandom;
      step(g);
    end
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    idle_inputs();
    #1;
    check_eq("rst_no_rvalid", t_rvalid, 1'b0);
    t_req = 1; p_req = 1;
    step(g);
    check_eq("post_rst_t_first", g, 2'b01);

    // Randomized traffic including illegal masks and sporadic resets
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      t_req   = ($urandom_range(0, 3) != 0);
      p_req   = ($urandom_range(0, 3) != 0);
      t_lock  = ($urandom_range(0, 9) < 7);
      p_lock  = ($urandom_range(0, 9) < 5);
      t_re    = 4'($urandom); p_re = 4'($urandom);
      t_we    = 4'($urandom); p_we = 4'($urandom);
      t_addr  = $urandom; p_addr = $urandom;
      t_wdata = $urandom; p_wdata = $urandom;
      glb_r_data = $urandom;
      step(g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
